// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : song_sequencer
// Purpose  : Fetches note entries from song memory and times play/gap periods
//            for a buzzer driver.
// Revision : 1.0 - initial release
// ============================================================================
module song_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int BEAT_DIV  = 1562500,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [8:0]        mem_data,
  output logic              play_en,
  output logic [1:0]        octave,
  output logic [2:0]        note,
  output logic              busy,
  output logic              done
);

  localparam int c_DIV_W  = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int c_TMAX   = (GAP_TICKS > 8) ? GAP_TICKS : 8;
  localparam int c_TICK_W = $clog2(c_TMAX);

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(BEAT_DIV - 1);
  localparam logic [c_TICK_W-1:0] c_GAP_LAST  = c_TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0]   c_ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_TICK_W-1:0] r_ticks;
  logic [1:0]          r_octave;
  logic [2:0]          r_note;
  logic [2:0]          r_len;
  logic                w_cnt_run;
  logic                w_seg_end;
  logic                w_addr_clr;
  logic                w_addr_inc;
  logic                w_latch;
  logic [c_TICK_W-1:0] w_tick_last;

  // Segment ends on the last prescaler cycle of its last tick, so PLAY/GAP
  // durations are exact multiples of BEAT_DIV from their own entry.
  assign w_tick_last = (r_state == S_PLAY) ? c_TICK_W'(r_len) : c_GAP_LAST;
  assign w_cnt_run   = ((r_state == S_PLAY) || (r_state == S_GAP)) && !pause;
  assign w_seg_end   = w_cnt_run && (r_div == c_DIV_LAST) && (r_ticks == w_tick_last);

  assign mem_addr = r_addr;
  assign octave   = r_octave;
  assign note     = r_note;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_clr   = 1'b0;
    w_addr_inc   = 1'b0;
    w_latch      = 1'b0;
    mem_rd       = 1'b0;
    play_en      = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = S_FETCH;
          w_addr_clr   = 1'b1;
        end
      end
      S_FETCH: begin
        mem_rd       = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          w_latch      = 1'b1;
          w_state_next = mem_data[8] ? S_DONE : S_PLAY;
        end
      end
      S_PLAY: begin
        play_en = !pause && (r_note != 3'd7);
        if (w_seg_end) begin
          if (GAP_TICKS > 0) begin
            w_state_next = S_GAP;
          end else if (r_addr == c_ADDR_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_addr_inc   = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      S_GAP: begin
        if (w_seg_end) begin
          if (r_addr == c_ADDR_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_addr_inc   = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // Stop overrides everything, including a same-cycle start.
    if (stop) begin
      w_state_next = S_IDLE;
      w_addr_clr   = 1'b1;
      w_addr_inc   = 1'b0;
      w_latch      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_div    <= '0;
      r_ticks  <= '0;
      r_octave <= '0;
      r_note   <= '0;
      r_len    <= '0;
    end else begin
      if (w_addr_clr) begin
        r_addr <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_latch) begin
        {r_octave, r_note, r_len} <= mem_data[7:0];
      end
      // Any state change restarts the timers; pause simply withholds the count.
      if (w_state_next != r_state) begin
        r_div   <= '0;
        r_ticks <= '0;
      end else if (w_cnt_run) begin
        if (r_div == c_DIV_LAST) begin
          r_div   <= '0;
          r_ticks <= r_ticks + c_TICK_W'(1);
        end else begin
          r_div <= r_div + c_DIV_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, song memory address width.
REQ-002 Parameter BEAT_DIV, default 1562500, clk cycles per length tick (>=2).
REQ-003 Parameter GAP_TICKS, default 1, silent ticks after each note (0 = no gap).
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous and active-low.
REQ-006 start  in  1  one-cycle pulse; begins playback from address 0.
REQ-007 stop  in  1  one-cycle pulse; aborts playback.
REQ-008 pause  in  1  level; freezes playback while high.
REQ-009 mem_rd  out  1  one-cycle read strobe to song memory.
REQ-010 mem_addr  out  ADDR_W  read address, valid while mem_rd high.
REQ-011 mem_valid  in  1  read data valid; arrives >=1 cycle after mem_rd.
REQ-012 mem_data  in  9  {end[8], octave[7:6], note[5:3], length[2:0]}.
REQ-013 play_en  out  1  buzzer enable for the current note.
REQ-014 octave  out  2  current octave.
REQ-015 note  out  3  current note 0-6; 7 = rest.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of song.

Function
REQ-018 States SHALL be IDLE, FETCH, WAIT, PLAY, GAP, DONE.
REQ-019 IDLE: start -> FETCH next cycle, address = 0.
REQ-020 FETCH: mem_rd high exactly one cycle with mem_addr = address; -> WAIT.
REQ-021 WAIT: hold until mem_valid; on that edge latch mem_data; end=1 -> DONE, else -> PLAY.
REQ-022 PLAY: lasts exactly (length+1)*BEAT_DIV unpaused cycles; play_en high throughout unless note = 7.
REQ-023 PLAY end: GAP_TICKS>0 -> GAP; else address+1 -> FETCH.
REQ-024 GAP: lasts exactly GAP_TICKS*BEAT_DIV unpaused cycles, play_en low, octave/note hold; then address+1 -> FETCH.
REQ-025 Prescaler and tick counter SHALL clear on entry to PLAY and GAP; durations are exact, not tick-aligned.
REQ-026 Address at 2^ADDR_W-1 after PLAY/GAP completes -> DONE; no wrap.
REQ-027 DONE: done high one cycle, play_en low; -> IDLE next cycle.
REQ-028 pause high in PLAY/GAP: counters frozen, play_en low; resume continues remaining count.
REQ-029 pause in FETCH/WAIT: no effect; mem_rd strobe and data capture proceed.
REQ-030 stop in any state: -> IDLE next cycle, play_en low, address 0, done not asserted.
REQ-031 start while busy: ignored; start and stop same cycle: stop wins.
REQ-032 mem_valid outside WAIT: ignored.

Reset
REQ-033 rst_n low: state IDLE, address 0, counters 0, mem_rd 0, play_en 0, octave 0, note 0, busy 0, done 0.
REQ-034 Reset asserted mid-PLAY: outputs go to reset values immediately, no done pulse.

Verification (BEAT_DIV=4, GAP_TICKS=1, memory returns mem_valid 1 cycle after mem_rd)
REQ-035 Song [oct1 note2 len1][end]: start -> mem_rd@0 addr0, play_en high 8 cycles with octave 1 note 2, low 4 cycles, mem_rd addr1, done pulse, busy low.
REQ-036 Entry note 7 len0: play_en stays low for 4 PLAY cycles, then 4 GAP cycles, next fetch on time.
REQ-037 pause high 5 cycles mid-PLAY of len0 note: play_en low during pause, total PLAY span 9 cycles.
REQ-038 stop during GAP of entry 3: IDLE next cycle, busy 0, no done; new start fetches addr 0.
REQ-039 Memory delays mem_valid 6 cycles: sequencer holds WAIT with mem_rd low, single strobe only.
REQ-040 rst_n low during PLAY with start pulse simultaneous: all outputs reset, IDLE held until next start after release.
